// File: rtl/rodada_sequencia_param.sv
// Round engine for the memory game: plays a sequence from ROM on the LEDs and then
// collects and checks the player's presses, each one under a per-play time limit.
module rodada_sequencia_param #(
   parameter int CANAIS    = 4,
   parameter int END_W     = 4,
   parameter int T_LED     = 1000,
   parameter int T_APAGA   = 50,
   parameter int T_TIMEOUT = 5000,
   parameter int TMR_W     = 16
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              iniciar_i,
   input  logic [END_W:0]    nivel_i,
   input  logic              dificuldade_i,
   input  logic [CANAIS-1:0] botoes_i,
   output logic [END_W-1:0]  endereco_o,
   input  logic [CANAIS-1:0] dado_rom_i,
   output logic [CANAIS-1:0] leds_o,
   output logic              ocupado_o,
   output logic              acertou_o,
   output logic              errou_o,
   output logic              timeout_o,
   output logic [3:0]        db_estado_o
);

   localparam logic [3:0] OCIOSO  = 4'd0;
   localparam logic [3:0] MOSTRA  = 4'd1;
   localparam logic [3:0] APAGA   = 4'd2;
   localparam logic [3:0] ESPERA  = 4'd3;
   localparam logic [3:0] SOLTA   = 4'd4;
   localparam logic [3:0] COMPARA = 4'd5;
   localparam logic [3:0] ACERTO  = 4'd6;
   localparam logic [3:0] ERRO    = 4'd7;
   localparam logic [3:0] ESGOTOU = 4'd8;

   localparam logic [TMR_W-1:0] LED_FIM   = TMR_W'(T_LED - 1);
   localparam logic [TMR_W-1:0] APAGA_FIM = TMR_W'(T_APAGA - 1);
   localparam logic [TMR_W-1:0] LIM_NORM  = TMR_W'(T_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] LIM_DIF   = TMR_W'((T_TIMEOUT >> 1) - 1);
   localparam logic [END_W:0]   NIVEL_MAX = {1'b1, {END_W{1'b0}}};

   logic [3:0]        estado_q, estado_d;
   logic [END_W-1:0]  idx_q, idx_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [END_W:0]    nivel_q, nivel_d;
   logic              dif_q, dif_d;
   logic [CANAIS-1:0] jogada_q, jogada_d;

   logic              nivel_ok, ultimo, um_quente, repouso;
   logic [TMR_W-1:0]  limite;

   assign nivel_ok  = (nivel_i != '0) && (nivel_i <= NIVEL_MAX);
   // Compare index+1 against nivel so no subtraction can underflow.
   assign ultimo    = (({1'b0, idx_q} + (END_W+1)'(1)) == nivel_q);
   assign um_quente = (jogada_q != '0) && ((jogada_q & (jogada_q - CANAIS'(1))) == '0);
   assign limite    = dif_q ? LIM_DIF : LIM_NORM;
   assign repouso   = (estado_q == OCIOSO) || (estado_q == ACERTO) ||
                      (estado_q == ERRO)   || (estado_q == ESGOTOU);

   always_comb begin
      estado_d = estado_q;
      idx_d    = idx_q;
      tmr_d    = tmr_q;
      nivel_d  = nivel_q;
      dif_d    = dif_q;
      jogada_d = jogada_q;
      case (estado_q)
         OCIOSO, ACERTO, ERRO, ESGOTOU: begin
            if (iniciar_i && nivel_ok) begin
               nivel_d  = nivel_i;
               dif_d    = dificuldade_i;
               idx_d    = '0;
               tmr_d    = '0;
               estado_d = MOSTRA;
            end
         end
         MOSTRA: begin
            if (tmr_q == LED_FIM) begin
               tmr_d    = '0;
               estado_d = APAGA;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         APAGA: begin
            if (tmr_q == APAGA_FIM) begin
               tmr_d = '0;
               if (ultimo) begin
                  idx_d    = '0;
                  estado_d = ESPERA;
               end else begin
                  idx_d    = idx_q + END_W'(1);
                  estado_d = MOSTRA;
               end
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         ESPERA: begin
            tmr_d = tmr_q + TMR_W'(1);
            // A press on the last allowed cycle still counts as a play.
            if (botoes_i != '0) begin
               jogada_d = botoes_i;
               estado_d = SOLTA;
            end else if (tmr_q == limite) begin
               estado_d = ESGOTOU;
            end
         end
         SOLTA: begin
            if (botoes_i == '0) estado_d = COMPARA;
         end
         COMPARA: begin
            if ((jogada_q != dado_rom_i) || !um_quente) begin
               estado_d = ERRO;
            end else if (ultimo) begin
               estado_d = ACERTO;
            end else begin
               idx_d    = idx_q + END_W'(1);
               tmr_d    = '0;
               estado_d = ESPERA;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         estado_q <= OCIOSO;
         idx_q    <= '0;
         tmr_q    <= '0;
         nivel_q  <= '0;
         dif_q    <= 1'b0;
         jogada_q <= '0;
      end else begin
         estado_q <= estado_d;
         idx_q    <= idx_d;
         tmr_q    <= tmr_d;
         nivel_q  <= nivel_d;
         dif_q    <= dif_d;
         jogada_q <= jogada_d;
      end
   end

   always_comb begin
      leds_o = '0;
      if (estado_q == MOSTRA)     leds_o = dado_rom_i;
      else if (estado_q == SOLTA) leds_o = jogada_q;
   end

   assign endereco_o  = idx_q;
   assign ocupado_o   = !repouso;
   assign acertou_o   = (estado_q == ACERTO);
   assign errou_o     = (estado_q == ERRO);
   assign timeout_o   = (estado_q == ESGOTOU);
   assign db_estado_o = estado_q;

endmodule

// File: tb/tb_rodada_sequencia_param.sv
// Directed bench for rodada_sequencia_param with a small one-hot ROM (0001,0010,0100,1000,...).
module tb_rodada_sequencia_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       iniciar;
   logic [4:0] nivel;
   logic       dif;
   logic [3:0] botoes;
   logic [3:0] endereco;
   logic [3:0] dado_rom;
   logic [3:0] leds;
   logic       ocupado, acertou, errou, tmo;
   logic [3:0] estado;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign dado_rom = 4'b0001 << endereco[1:0];

   rodada_sequencia_param #(
      .CANAIS(4), .END_W(4), .T_LED(4), .T_APAGA(2), .T_TIMEOUT(20), .TMR_W(8)
   ) dut (
      .clock_i(clk), .reset_i(rst_n), .iniciar_i(iniciar), .nivel_i(nivel),
      .dificuldade_i(dif), .botoes_i(botoes), .endereco_o(endereco),
      .dado_rom_i(dado_rom), .leds_o(leds), .ocupado_o(ocupado),
      .acertou_o(acertou), .errou_o(errou), .timeout_o(tmo), .db_estado_o(estado)
   );

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start(input logic [4:0] nv, input logic d);
      iniciar = 1'b1; nivel = nv; dif = d;
      tick();
      iniciar = 1'b0;
   endtask

   // Press, hold 3 cycles, release; returns positioned in the COMPARA cycle.
   task automatic press(input logic [3:0] v);
      botoes = v;
      tick(3);
      botoes = 4'b0000;
      tick();
   endtask

   task automatic test_reset;
      rst_n = 1'b0; iniciar = 1'b0; nivel = '0; dif = 1'b0; botoes = '0;
      tick(2);
      n_chk++;
      if ({estado, leds, ocupado, acertou, errou, tmo, endereco} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_init: estado=%0d leds=%b oc=%b a=%b e=%b t=%b end=%0d want all 0",
                  estado, leds, ocupado, acertou, errou, tmo, endereco);
      end
      rst_n = 1'b1;
      start(5'd3, 1'b0);
      tick(2);
      n_chk++;
      if (estado !== 4'd1 || leds !== 4'b0001) begin
         n_err++; $display("FAIL mid_mostra: estado=%0d leds=%b want 1/0001", estado, leds);
      end
      rst_n = 1'b0;
      tick();
      n_chk++;
      if ({estado, leds, ocupado, acertou, errou, tmo, endereco} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_mid: estado=%0d leds=%b oc=%b a=%b e=%b t=%b end=%0d want all 0",
                  estado, leds, ocupado, acertou, errou, tmo, endereco);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_pass3;
      logic [3:0] tr [18] = '{4'h1,4'h1,4'h1,4'h1,4'h0,4'h0, 4'h2,4'h2,4'h2,4'h2,4'h0,4'h0,
                              4'h4,4'h4,4'h4,4'h4,4'h0,4'h0};
      int bad = 0;
      start(5'd3, 1'b0);
      for (int i = 0; i < 18; i++) begin
         if (leds !== tr[i]) begin
            bad++;
            $display("FAIL led_trace[%0d]: leds=%b want %b", i, leds, tr[i]);
         end
         tick();
      end
      n_chk++;
      if (bad != 0) n_err++;
      n_chk++;
      if (estado !== 4'd3 || leds !== 4'b0000 || ocupado !== 1'b1) begin
         n_err++; $display("FAIL espera_entry: estado=%0d leds=%b oc=%b want 3/0000/1", estado, leds, ocupado);
      end
      botoes = 4'b0001;
      tick();
      n_chk++;
      if (estado !== 4'd4 || leds !== 4'b0001) begin
         n_err++; $display("FAIL echo: estado=%0d leds=%b want 4/0001", estado, leds);
      end
      tick(2);
      botoes = 4'b0000;
      tick(2);
      n_chk++;
      if (estado !== 4'd3 || endereco !== 4'd1) begin
         n_err++; $display("FAIL play2_idx: estado=%0d end=%0d want 3/1", estado, endereco);
      end
      press(4'b0010); tick();
      press(4'b0100);
      n_chk++;
      if (estado !== 4'd5 || acertou !== 1'b0) begin
         n_err++; $display("FAIL compara3: estado=%0d acertou=%b want 5/0", estado, acertou);
      end
      tick();
      n_chk++;
      if (acertou !== 1'b1 || errou !== 1'b0 || ocupado !== 1'b0 || leds !== 4'b0) begin
         n_err++; $display("FAIL acerto3: a=%b e=%b oc=%b leds=%b want 1/0/0/0000", acertou, errou, ocupado, leds);
      end
   endtask

   task automatic test_wrong;
      start(5'd2, 1'b0);
      n_chk++;
      if (estado !== 4'd1 || acertou !== 1'b0 || ocupado !== 1'b1) begin
         n_err++; $display("FAIL restart_from_acerto: estado=%0d a=%b oc=%b want 1/0/1", estado, acertou, ocupado);
      end
      tick(12);
      press(4'b0010); tick();
      n_chk++;
      if (errou !== 1'b1 || acertou !== 1'b0 || estado !== 4'd7) begin
         n_err++; $display("FAIL wrong_press: e=%b a=%b estado=%0d want 1/0/7", errou, acertou, estado);
      end
   endtask

   task automatic test_nonhot;
      start(5'd1, 1'b0);
      tick(6);
      press(4'b0011); tick();
      n_chk++;
      if (errou !== 1'b1 || acertou !== 1'b0) begin
         n_err++; $display("FAIL nonhot: e=%b a=%b want 1/0", errou, acertou);
      end
   endtask

   task automatic test_timeout;
      start(5'd1, 1'b0);
      tick(6);
      tick(19);
      n_chk++;
      if (estado !== 4'd3 || tmo !== 1'b0) begin
         n_err++; $display("FAIL tmo_early20: estado=%0d t=%b want 3/0", estado, tmo);
      end
      tick();
      n_chk++;
      if (tmo !== 1'b1 || estado !== 4'd8 || ocupado !== 1'b0) begin
         n_err++; $display("FAIL tmo20: t=%b estado=%0d oc=%b want 1/8/0", tmo, estado, ocupado);
      end
      start(5'd0, 1'b0);
      n_chk++;
      if (estado !== 4'd8 || tmo !== 1'b1) begin
         n_err++; $display("FAIL invalid_in_final: estado=%0d t=%b want 8/1", estado, tmo);
      end
      start(5'd1, 1'b1);
      tick(6);
      tick(9);
      n_chk++;
      if (estado !== 4'd3) begin
         n_err++; $display("FAIL tmo_early10: estado=%0d want 3", estado);
      end
      tick();
      n_chk++;
      if (tmo !== 1'b1 || estado !== 4'd8) begin
         n_err++; $display("FAIL tmo10: t=%b estado=%0d want 1/8", tmo, estado);
      end
      start(5'd1, 1'b1);
      tick(6);
      tick(9);
      botoes = 4'b0001;
      tick();
      n_chk++;
      if (estado !== 4'd4 || tmo !== 1'b0) begin
         n_err++; $display("FAIL press_on_limit: estado=%0d t=%b want 4/0", estado, tmo);
      end
      botoes = 4'b0000;
      tick(2);
      n_chk++;
      if (acertou !== 1'b1) begin
         n_err++; $display("FAIL limit_play_ok: a=%b want 1", acertou);
      end
   endtask

   task automatic test_nivel16;
      int bad = 0;
      start(5'd16, 1'b0);
      iniciar = 1'b1; nivel = 5'd1;
      tick();
      iniciar = 1'b0;
      tick(95);
      for (int i = 0; i < 16; i++) begin
         if (endereco !== 4'(i) || estado !== 4'd3) begin
            bad++; $display("FAIL n16_idx[%0d]: end=%0d estado=%0d want %0d/3", i, endereco, estado, i);
         end
         press(4'b0001 << (i % 4)); tick();
      end
      n_chk++;
      if (bad != 0) n_err++;
      n_chk++;
      if (acertou !== 1'b1 || endereco !== 4'd15) begin
         n_err++; $display("FAIL n16_done: a=%b end=%0d want 1/15", acertou, endereco);
      end
      start(5'd4, 1'b0);
      n_chk++;
      if (estado !== 4'd1 || endereco !== 4'd0 || leds !== 4'b0001) begin
         n_err++; $display("FAIL n16_restart: estado=%0d end=%0d leds=%b want 1/0/0001", estado, endereco, leds);
      end
   endtask

   task automatic test_invalid;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      start(5'd0, 1'b0);
      n_chk++;
      if (estado !== 4'd0 || ocupado !== 1'b0) begin
         n_err++; $display("FAIL nivel0: estado=%0d oc=%b want 0/0", estado, ocupado);
      end
      start(5'd17, 1'b0);
      n_chk++;
      if (estado !== 4'd0 || ocupado !== 1'b0) begin
         n_err++; $display("FAIL nivel17: estado=%0d oc=%b want 0/0", estado, ocupado);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_pass3();
      test_wrong();
      test_nonhot();
      test_timeout();
      test_nivel16();
      test_invalid();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
